hbm_rd_stream_buffer: RTL and testbench
=======================================

Name: hbm_rd_stream_buffer

Overview:
- Downstream consumer of the HBM auto-read engine's `dn_vld`/`dn_dat` beat stream.
- The read engine holds RREADY at 1, so this block must accept every beat unconditionally.
- Beats are buffered in a FIFO and re-issued on a valid/ready stream to compute logic.
- Per job it counts received and delivered beats, marks the final beat, and pulses done.
- It exports a burst-credit flag so control only issues `start_read` when a whole job fits.

Parameters:
- DATA_WIDTH, 256, beat width in bits (matches the read engine's data width).
- DEPTH, 64, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy and free-count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a job; ignored unless state is IDLE
- expected_beats  in  32  beats in this job; latched on an accepted start
- burst_beats  in  16  beats the next read job will request (credit check)
- up_vld  in  1  beat valid from the read engine; no backpressure
- up_dat  in  DATA_WIDTH  beat data from the read engine
- dn_vld  out  1  output beat valid
- dn_rdy  in  1  consumer ready
- dn_dat  out  DATA_WIDTH  output beat data
- dn_last  out  1  qualifies the final beat of the job
- burst_ok  out  1  free entries >= burst_beats
- free_cnt  out  CNT_W  free FIFO entries
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion
- overflow  out  1  sticky: a beat was dropped because the FIFO was full
- stray  out  1  sticky: a beat arrived in IDLE or after all expected beats were received

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; pointers, occupancy and counters = 0.
  - dn_vld=0, dn_last=0, done=0, overflow=0, stray=0, busy=0.
  - free_cnt=DEPTH; burst_ok=(DEPTH>=burst_beats).
  - dn_dat is don't-care while dn_vld=0.
- FIFO:
  - First-word fall-through: dn_vld = occupancy != 0, dn_dat = entry at the read pointer.
  - Latency from up_vld to dn_vld is 1 cycle (registered write, combinational head read).
  - push = up_vld & accept_ok & !full_block.
  - pop = dn_vld & dn_rdy.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is CNT_W bits.
  - free_cnt = DEPTH - occupancy. burst_ok is combinational from free_cnt.
  - Simultaneous push and pop: occupancy unchanged. This is also allowed when full, so the beat is accepted.
  - full_block = (occupancy == DEPTH) & !pop. A beat blocked this way is dropped and sets overflow; rx_cnt still increments.
  - Pop while empty is impossible because dn_vld=0.
- State machine:
  - IDLE:
    - On start: latch exp = expected_beats, clear rx_cnt and tx_cnt, go to RUN.
    - If start arrives with expected_beats==0: pulse done the next cycle and remain in IDLE.
    - up_vld in IDLE sets stray; the beat is not written.
  - RUN:
    - accept_ok=1 while rx_cnt < exp; each up_vld increments rx_cnt.
    - up_vld when rx_cnt == exp sets stray and the beat is dropped.
    - Go to DRAIN when rx_cnt reaches exp (same edge as the last receive).
  - DRAIN: no writes accepted (stray on up_vld). Wait for tx_cnt == exp.
  - Counting and completion (RUN and DRAIN):
    - tx_cnt increments on each pop.
    - dn_last = dn_vld & (tx_cnt == exp-1).
    - A pop with dn_last registers done=1 for one cycle and returns to IDLE.
    - If the final beat was dropped by overflow, tx_cnt cannot reach exp. The job then ends when rx_cnt == exp and the FIFO is empty: pulse done with overflow set and go to IDLE.
- Counters: rx_cnt, tx_cnt and exp are 32-bit unsigned; comparisons are unsigned.
- overflow and stray clear only on reset or on an accepted start.
- start while busy: ignored, with no effect on counters or flags.

Test Plan:
- Nominal job:
  - Stimulus: DEPTH=64; start with expected_beats=16; 16 back-to-back up_vld beats with data 0..15; dn_rdy=1.
  - Response: dn_dat 0..15 in order, first valid 1 cycle after the first up_vld; dn_last on data 15; done 1 cycle after that pop; overflow=0; free_cnt returns to 64.
- Backpressure and credit:
  - Stimulus: expected_beats=64; dn_rdy=0 while 64 beats arrive.
  - Response: free_cnt=0; burst_ok=0 for burst_beats=8. Then dn_rdy=1: all 64 beats drain in order and burst_ok rises once free_cnt >= 8.
- Full with simultaneous pop:
  - Stimulus: fill to 64; next cycle assert up_vld and dn_rdy together.
  - Response: beat accepted, occupancy stays 64, overflow=0.
- Overflow:
  - Stimulus: expected_beats=70; dn_rdy=0; 70 beats arrive.
  - Response: beats 65..70 dropped, overflow=1, free_cnt=0. Then dn_rdy=1: 64 beats drain, done pulses, state returns to IDLE.
- Stray and ignored start:
  - Stimulus: up_vld in IDLE; separately, a second start mid-job.
  - Response: stray=1 and no data emitted; the second start does not change the current job's beat count.
- Edge cases:
  - Stimulus: start with expected_beats=0; separately, assert rst_n=0 mid-job with 10 beats buffered.
  - Response: for the zero-beat start, done pulses and busy stays 0. For the reset, dn_vld=0, free_cnt=64 and state=IDLE immediately (asynchronous).

Source files
------------

// File: rtl/hbm_rd_stream_buffer.sv
// hbm_rd_stream_buffer: absorbs the HBM auto-read beat stream with no
// backpressure and replays it on a valid/ready stream. It tracks per-job
// received and delivered beats, flags the final beat, pulses done at
// completion, and reports whether a whole read burst would fit.
module hbm_rd_stream_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 64,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           expected_beats,
  input  logic [15:0]           burst_beats,
  input  logic                  up_vld,
  input  logic [DATA_WIDTH-1:0] up_dat,
  output logic                  dn_vld,
  input  logic                  dn_rdy,
  output logic [DATA_WIDTH-1:0] dn_dat,
  output logic                  dn_last,
  output logic                  burst_ok,
  output logic [CNT_W-1:0]      free_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  stray
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      occ;
  logic [31:0]           exp_cnt, rx_cnt, tx_cnt;
  logic                  done_r, done_next, overflow_r, stray_r;

  logic start_acc, accept_ok, pop, push, full_block;
  logic rx_inc, drop, stray_set, last_pop;

  // Datapath qualifiers: the upstream cannot be stalled, so every beat is
  // either written, dropped as overflow, or dropped as stray.
  always_comb begin
    start_acc  = start & (state == IDLE);
    accept_ok  = (state == RUN) & (rx_cnt < exp_cnt);
    pop        = dn_vld & dn_rdy;
    full_block = (occ == DEPTH_C) & ~pop;
    rx_inc     = up_vld & accept_ok;
    push       = rx_inc & ~full_block;
    drop       = rx_inc & full_block;
    stray_set  = up_vld & ~accept_ok;
    last_pop   = pop & dn_last;
  end

  // Output view of the FIFO head and credit.
  always_comb begin
    dn_vld   = (occ != '0);
    dn_dat   = mem[rd_ptr];
    dn_last  = dn_vld & (state != IDLE) & (tx_cnt == exp_cnt - 32'd1);
    free_cnt = DEPTH_C - occ;
    burst_ok = 32'(free_cnt) >= 32'(burst_beats);
    busy     = (state != IDLE);
    done     = done_r;
    overflow = overflow_r;
    stray    = stray_r;
  end

  // Job sequencing; DRAIN with an empty FIFO only happens when a beat was
  // lost to overflow, so that also ends the job.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (expected_beats == 32'd0) done_next = 1'b1;
          else                         state_next = RUN;
        end
      end
      RUN: begin
        if (last_pop) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (rx_inc && (rx_cnt + 32'd1 == exp_cnt)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop || (occ == '0)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= done_next;
    end
  end

  // Job counters: latched and cleared on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cnt <= '0;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
    end else if (start_acc) begin
      exp_cnt <= expected_beats;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
    end else begin
      if (rx_inc) rx_cnt <= rx_cnt + 32'd1;
      if (pop)    tx_cnt <= tx_cnt + 32'd1;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Beat storage; contents need no reset since dn_vld qualifies them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up_dat;
  end

  // Sticky error flags, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      stray_r    <= 1'b0;
    end else begin
      if (start_acc) begin
        overflow_r <= 1'b0;
        stray_r    <= 1'b0;
      end
      if (drop)      overflow_r <= 1'b1;
      if (stray_set) stray_r    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hbm_rd_stream_buffer.sv
// Bench for hbm_rd_stream_buffer: a fixed vector table, directed corner
// sequences, and randomized jobs checked against a queue-based model.
module tb_hbm_rd_stream_buffer;
  localparam int DW    = 256;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic             clk, rst_n, start, up_vld, dn_rdy;
  logic [31:0]      expected_beats;
  logic [15:0]      burst_beats;
  logic [DW-1:0]    up_dat, dn_dat;
  logic             dn_vld, dn_last, burst_ok, busy, done, overflow, stray;
  logic [CNT_W-1:0] free_cnt;

  int checks = 0;
  int failures = 0;

  hbm_rd_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected_beats(expected_beats),
    .burst_beats(burst_beats), .up_vld(up_vld), .up_dat(up_dat),
    .dn_vld(dn_vld), .dn_rdy(dn_rdy), .dn_dat(dn_dat), .dn_last(dn_last),
    .burst_ok(burst_ok), .free_cnt(free_cnt), .busy(busy), .done(done),
    .overflow(overflow), .stray(stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the buffered beats plus job bookkeeping.
  logic [DW-1:0] m_q[$];
  bit            m_active, m_done, m_ovf, m_stray;
  int unsigned   m_exp, m_rx, m_tx;

  // DUT samples taken at the check point of the latest cycle.
  logic s_vld, s_last, s_done, s_busy, s_ovf, s_bok;
  logic [CNT_W-1:0] s_free;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_done = 0; m_ovf = 0; m_stray = 0;
    m_exp = 0; m_rx = 0; m_tx = 0;
  endtask

  task automatic check_model();
    bit ev;
    int free;
    ev   = (m_q.size() != 0);
    free = DEPTH - m_q.size();
    chk("dn_vld", DW'(dn_vld), DW'(ev));
    if (ev) chk("dn_dat", dn_dat, m_q[0]);
    chk("dn_last", DW'(dn_last), DW'(ev && m_active && (m_tx + 1 == m_exp)));
    chk("free_cnt", DW'(free_cnt), DW'(free));
    chk("burst_ok", DW'(burst_ok), DW'(free >= int'(burst_beats)));
    chk("busy", DW'(busy), DW'(m_active));
    chk("done", DW'(done), DW'(m_done));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("stray", DW'(stray), DW'(m_stray));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    bit pop, push, fin, was_active;
    pop = (m_q.size() != 0) && dn_rdy;
    push = 0; fin = 0;
    was_active = m_active;
    if (!was_active) begin
      if (start) begin
        m_ovf = 0; m_stray = 0;
        m_exp = expected_beats; m_rx = 0; m_tx = 0;
        if (expected_beats == 0) fin = 1;
        else m_active = 1;
      end
      if (up_vld) m_stray = 1;
    end else begin
      if (pop && (m_tx + 1 == m_exp)) fin = 1;
      else if ((m_rx == m_exp) && (m_q.size() == 0)) fin = 1;
      if (up_vld) begin
        if (m_rx < m_exp) begin
          m_rx++;
          if ((m_q.size() == DEPTH) && !pop) m_ovf = 1;
          else push = 1;
        end else begin
          m_stray = 1;
        end
      end
      if (pop) m_tx++;
      if (fin) m_active = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(up_dat);
    m_done = fin;
  endtask

  // One clock: check mid-cycle, then step DUT and model together.
  task automatic cycle();
    #4;
    s_vld = dn_vld; s_last = dn_last; s_done = done; s_busy = busy;
    s_ovf = overflow; s_bok = burst_ok; s_free = free_cnt;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; up_vld = 0; dn_rdy = 0; expected_beats = 0; up_dat = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    burst_beats = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct packed {
    logic        start;
    logic [31:0] eb;
    logic        up;
    logic [7:0]  dat;
    logic        rdy;
    logic [15:0] burst;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_last;
    logic        e_done;
    logic        e_busy;
    logic [6:0]  e_free;
    logic        e_bok;
    logic        e_stray;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int pops, lasts, n, rdy_pct, eb;
    bit done_seen;

    rst_n = 0;
    idle_inputs();
    burst_beats = 16'd64;
    model_reset();
    #3;
    chk("rst_dn_vld", DW'(dn_vld), DW'(0));
    chk("rst_dn_last", DW'(dn_last), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_overflow", DW'(overflow), DW'(0));
    chk("rst_stray", DW'(stray), DW'(0));
    chk("rst_free_cnt", DW'(free_cnt), DW'(64));
    chk("rst_burst_ok_64", DW'(burst_ok), DW'(1));
    burst_beats = 16'd65;
    #1;
    chk("rst_burst_ok_65", DW'(burst_ok), DW'(0));
    do_reset();

    // start eb up dat rdy burst | vld dat last done busy free bok stray
    tbl[0]  = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 16'd65, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd64, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'd2, 1'b0, 8'h00, 1'b0, 16'd64, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd64, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 32'd0, 1'b1, 8'hA1, 1'b0, 16'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd64, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'd0, 1'b1, 8'hB2, 1'b0, 16'd63, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 7'd63, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b1, 16'd63, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 7'd62, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b1, 16'd0,  1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 7'd63, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 16'd0,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd64, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'd0, 1'b1, 8'hC3, 1'b0, 16'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd64, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 16'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd64, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 32'd0, 1'b0, 8'h00, 1'b0, 16'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd64, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 16'd0,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd64, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 16'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd64, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start; expected_beats = tbl[i].eb; up_vld = tbl[i].up;
      up_dat = DW'(tbl[i].dat); dn_rdy = tbl[i].rdy; burst_beats = tbl[i].burst;
      #4;
      chk($sformatf("tbl%0d_dn_vld", i), DW'(dn_vld), DW'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_dn_dat", i), dn_dat, DW'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_dn_last", i), DW'(dn_last), DW'(tbl[i].e_last));
      chk($sformatf("tbl%0d_done", i), DW'(done), DW'(tbl[i].e_done));
      chk($sformatf("tbl%0d_busy", i), DW'(busy), DW'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_free_cnt", i), DW'(free_cnt), DW'(tbl[i].e_free));
      chk($sformatf("tbl%0d_burst_ok", i), DW'(burst_ok), DW'(tbl[i].e_bok));
      chk($sformatf("tbl%0d_stray", i), DW'(stray), DW'(tbl[i].e_stray));
      @(posedge clk);
      #1;
    end
    do_reset();

    // Fill to full, then push and pop together while full.
    start = 1; expected_beats = 66; burst_beats = 8; cycle(); start = 0;
    for (int i = 0; i < 64; i++) begin up_vld = 1; up_dat = DW'(i); cycle(); end
    up_vld = 0; cycle();
    chk("full_free_cnt", DW'(s_free), DW'(0));
    chk("full_burst_ok", DW'(s_bok), DW'(0));
    up_vld = 1; up_dat = DW'(64); dn_rdy = 1; cycle();
    up_vld = 0; dn_rdy = 0; cycle();
    chk("simul_free_cnt", DW'(s_free), DW'(0));
    chk("simul_overflow", DW'(s_ovf), DW'(0));
    up_vld = 1; up_dat = DW'(65); dn_rdy = 1; cycle(); up_vld = 0;
    lasts = 0; done_seen = 0; n = 0;
    while (m_active && n < 300) begin cycle(); if (s_last) lasts++; n++; end
    cycle(); if (s_done) done_seen = 1;
    chk("simul_last_count", DW'(lasts), DW'(1));
    chk("simul_done", DW'(done_seen), DW'(1));
    $display("job full_simul beats=66 cycles=%0d", n);

    // Overflow: 70 beats into 64 entries with the consumer stalled.
    idle_inputs(); start = 1; expected_beats = 70; cycle(); start = 0;
    for (int i = 0; i < 70; i++) begin up_vld = 1; up_dat = rand_dat(); cycle(); end
    up_vld = 0; cycle();
    chk("ovf_flag", DW'(s_ovf), DW'(1));
    chk("ovf_free_cnt", DW'(s_free), DW'(0));
    dn_rdy = 1; pops = 0; done_seen = 0; n = 0;
    while (m_active && n < 300) begin cycle(); if (s_vld) pops++; n++; end
    cycle(); if (s_done) done_seen = 1;
    chk("ovf_pops", DW'(pops), DW'(64));
    chk("ovf_done", DW'(done_seen), DW'(1));
    chk("ovf_busy_after", DW'(busy), DW'(0));
    $display("job overflow beats=70 popped=%0d", pops);

    // Ignored start in the middle of a 5-beat job.
    idle_inputs(); start = 1; expected_beats = 5; cycle(); start = 0;
    dn_rdy = 1; pops = 0; lasts = 0;
    for (int i = 0; i < 5; i++) begin
      up_vld = 1; up_dat = rand_dat();
      start = (i == 2); expected_beats = (i == 2) ? 32'd1 : 32'd0;
      cycle(); if (s_vld) pops++; if (s_last) lasts++;
    end
    idle_inputs(); dn_rdy = 1; n = 0;
    while (m_active && n < 50) begin cycle(); if (s_vld) pops++; if (s_last) lasts++; n++; end
    chk("ign_start_pops", DW'(pops), DW'(5));
    chk("ign_start_last", DW'(lasts), DW'(1));
    $display("job ignored_start beats=5 popped=%0d", pops);
    idle_inputs(); cycle();

    // Asynchronous reset mid-job with 10 beats buffered.
    start = 1; expected_beats = 20; cycle(); start = 0;
    for (int i = 0; i < 10; i++) begin up_vld = 1; up_dat = rand_dat(); cycle(); end
    up_vld = 0; cycle();
    chk("prerst_free_cnt", DW'(s_free), DW'(54));
    #4 rst_n = 0;
    #1;
    chk("arst_dn_vld", DW'(dn_vld), DW'(0));
    chk("arst_free_cnt", DW'(free_cnt), DW'(64));
    chk("arst_busy", DW'(busy), DW'(0));
    idle_inputs(); model_reset();
    @(posedge clk); #1 rst_n = 1;
    $display("job async_reset buffered=10");

    // Randomized jobs against the model.
    for (int j = 0; j < 30; j++) begin
      case ($urandom_range(0, 2))
        0: rdy_pct = 10;
        1: rdy_pct = 50;
        default: rdy_pct = 95;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        up_vld = 1; up_dat = rand_dat(); cycle(); up_vld = 0;
      end
      eb = $urandom_range(0, 80);
      start = 1; expected_beats = eb; burst_beats = 16'($urandom_range(0, 70));
      dn_rdy = 0; cycle(); start = 0;
      n = 0;
      while (m_active && n < 6000) begin
        up_vld = ($urandom_range(0, 3) != 0) && ((m_rx < m_exp) || ($urandom_range(0, 19) == 0));
        up_dat = rand_dat();
        dn_rdy = ($urandom_range(0, 99) < rdy_pct);
        start = ($urandom_range(0, 49) == 0);
        expected_beats = $urandom;
        burst_beats = 16'($urandom_range(0, 70));
        cycle();
        n++;
      end
      idle_inputs();
      checks++;
      if (m_active) begin
        failures++;
        $display("FAIL job%0d_timeout actual=%0d cycles required=completion", j, n);
        model_reset();
        do_reset();
      end
      cycle();
      $display("job %0d beats=%0d rdy_pct=%0d cycles=%0d", j, eb, rdy_pct, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
